// File: rtl/gray_ptr_counter.sv
// gray_ptr_counter
//   One side of an asynchronous FIFO pointer pair. Holds a Width+1 bit
//   binary pointer, exports its Gray encoding for CDC, and derives the
//   full (write side) or empty (read side) flag, an almost flag and the
//   occupancy level from the local next pointer and the opposite side's
//   already-synchronised Gray pointer.
//
//   Parameters
//     Width     : address bits (2..16), Depth = 2**Width
//     Side      : 0 = write side (flag is full), 1 = read side (flag is empty)
//     AlmostThr : almost-full / almost-empty margin in entries (0..Depth-1)
//
//   Ports
//     clk_i       : clock, rising edge
//     rst_i       : synchronous active-high reset
//     inc_i       : advance request (ignored while flag_o is set)
//     clear_i     : synchronous local pointer clear, wins over inc_i
//     sync_gray_i : opposite-side Gray pointer, already in clk_i domain
//     bin_count_o : binary address ptr[Width-1:0]
//     gray_ptr_o  : registered Gray pointer
//     msb_o       : wrap bit ptr[Width]
//     flag_o      : full (Side=0) / empty (Side=1)
//     almost_o    : almost-full / almost-empty
//     level_o     : occupancy 0..Depth
//     err_o       : sticky overflow / underflow attempt
module gray_ptr_counter #(
   parameter int Width     = 3,
   parameter int Side      = 0,
   parameter int AlmostThr = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clear_i,
   input  logic [Width:0]   sync_gray_i,
   output logic [Width-1:0] bin_count_o,
   output logic [Width:0]   gray_ptr_o,
   output logic             msb_o,
   output logic             flag_o,
   output logic             almost_o,
   output logic [Width:0]   level_o,
   output logic             err_o
);

   localparam int Depth = 2 ** Width;
   localparam logic [Width:0] AlmostFullLvl  = (Width + 1)'(Depth - AlmostThr);
   localparam logic [Width:0] AlmostEmptyLvl = (Width + 1)'(AlmostThr);
   localparam logic           FlagRst        = (Side != 0);

   logic [Width:0] ptr;
   logic [Width:0] ptr_nxt;
   logic [Width:0] gray_nxt;
   logic [Width:0] rb;
   logic [Width:0] lvl_nxt;
   logic           flag_nxt;
   logic           almost_nxt;
   logic           err_nxt;

   // Next pointer and sticky error. The flag used to block the increment is
   // the registered one, which already reflects the current pointer.
   always_comb begin
      ptr_nxt = ptr;
      err_nxt = err_o;
      if (clear_i) begin
         ptr_nxt = '0;
         err_nxt = 1'b0;
      end else if (inc_i) begin
         if (flag_o) err_nxt = 1'b1;
         else        ptr_nxt = ptr + 1'b1;
      end
   end

   assign gray_nxt = ptr_nxt ^ (ptr_nxt >> 1);

   // Gray to binary: bit i is the XOR of all Gray bits from i upward.
   always_comb begin
      rb = '0;
      for (int i = 0; i <= Width; i++) rb[i] = ^(sync_gray_i >> i);
   end

   // Flags are computed from the next pointer so they land on the same edge
   // the pointer reaches the boundary.
   generate
      if (Side == 0) begin : g_wr
         // Full: remote pointer is exactly one lap behind, which in Gray form
         // means the top two bits differ and the rest match.
         assign flag_nxt   = gray_nxt == {~sync_gray_i[Width:Width-1], sync_gray_i[Width-2:0]};
         assign lvl_nxt    = ptr_nxt - rb;
         assign almost_nxt = lvl_nxt >= AlmostFullLvl;
      end else begin : g_rd
         assign flag_nxt   = gray_nxt == sync_gray_i;
         assign lvl_nxt    = rb - ptr_nxt;
         assign almost_nxt = lvl_nxt <= AlmostEmptyLvl;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr        <= '0;
         gray_ptr_o <= '0;
         level_o    <= '0;
         err_o      <= 1'b0;
         flag_o     <= FlagRst;
         almost_o   <= FlagRst;
      end else begin
         ptr        <= ptr_nxt;
         gray_ptr_o <= gray_nxt;
         level_o    <= lvl_nxt;
         err_o      <= err_nxt;
         flag_o     <= flag_nxt;
         almost_o   <= almost_nxt;
      end
   end

   assign bin_count_o = ptr[Width-1:0];
   assign msb_o       = ptr[Width];

endmodule

// File: tb/tb_gray_ptr_counter.sv
module tb_gray_ptr_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       inc_w, clear_w, inc_r, clear_r;
   logic [3:0] sync_w, sync_r;
   logic [2:0] bin_w, bin_r;
   logic [3:0] gray_w, gray_r, lvl_w, lvl_r;
   logic       msb_w, msb_r, flag_w, flag_r, alm_w, alm_r, err_w, err_r;

   int errors = 0;
   int checks = 0;

   gray_ptr_counter #(.Width(3), .Side(0), .AlmostThr(2)) u_wr (
      .clk_i(clk), .rst_i(rst), .inc_i(inc_w), .clear_i(clear_w),
      .sync_gray_i(sync_w), .bin_count_o(bin_w), .gray_ptr_o(gray_w),
      .msb_o(msb_w), .flag_o(flag_w), .almost_o(alm_w), .level_o(lvl_w),
      .err_o(err_w));

   gray_ptr_counter #(.Width(3), .Side(1), .AlmostThr(1)) u_rd (
      .clk_i(clk), .rst_i(rst), .inc_i(inc_r), .clear_i(clear_r),
      .sync_gray_i(sync_r), .bin_count_o(bin_r), .gray_ptr_o(gray_r),
      .msb_o(msb_r), .flag_o(flag_r), .almost_o(alm_r), .level_o(lvl_r),
      .err_o(err_r));

   typedef struct {
      bit         side;
      bit         inc;
      bit         clr;
      logic [3:0] sync;
      logic [3:0] gray;
      logic [2:0] bin;
      bit         msb;
      bit         flag;
      bit         almost;
      logic [3:0] level;
      bit         err;
   } vec_t;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_out(string tag, bit side, logic [3:0] g, logic [2:0] b,
                          bit m, bit f, bit a, logic [3:0] l, bit e);
      if (side == 1'b0) begin
         chk({tag, ".gray"},   32'(gray_w), 32'(g));
         chk({tag, ".bin"},    32'(bin_w),  32'(b));
         chk({tag, ".msb"},    32'(msb_w),  32'(m));
         chk({tag, ".flag"},   32'(flag_w), 32'(f));
         chk({tag, ".almost"}, 32'(alm_w),  32'(a));
         chk({tag, ".level"},  32'(lvl_w),  32'(l));
         chk({tag, ".err"},    32'(err_w),  32'(e));
      end else begin
         chk({tag, ".gray"},   32'(gray_r), 32'(g));
         chk({tag, ".bin"},    32'(bin_r),  32'(b));
         chk({tag, ".msb"},    32'(msb_r),  32'(m));
         chk({tag, ".flag"},   32'(flag_r), 32'(f));
         chk({tag, ".almost"}, 32'(alm_r),  32'(a));
         chk({tag, ".level"},  32'(lvl_r),  32'(l));
         chk({tag, ".err"},    32'(err_r),  32'(e));
      end
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] to_gray(logic [3:0] x);
      return x ^ (x >> 1);
   endfunction

   vec_t tbl[$];

   initial begin
      // Write side, AlmostThr=2, remote pointer at 0: gray walk to full.
      //        side inc clr sync     gray     bin   msb flag alm level  err
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b0001, 3'd1, 0, 0, 0, 4'd1, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b0011, 3'd2, 0, 0, 0, 4'd2, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b0010, 3'd3, 0, 0, 0, 4'd3, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b0110, 3'd4, 0, 0, 0, 4'd4, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b0111, 3'd5, 0, 0, 0, 4'd5, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b0101, 3'd6, 0, 0, 1, 4'd6, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b0100, 3'd7, 0, 0, 1, 4'd7, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b1100, 3'd0, 1, 1, 1, 4'd8, 0});
      tbl.push_back('{0, 1, 0, 4'b0000, 4'b1100, 3'd0, 1, 1, 1, 4'd8, 1});
      tbl.push_back('{0, 0, 0, 4'b0000, 4'b1100, 3'd0, 1, 1, 1, 4'd8, 1});
      // Read side, remote pointer binary 5: drain to empty, then overrun.
      tbl.push_back('{1, 1, 0, 4'b0111, 4'b0001, 3'd1, 0, 0, 0, 4'd4, 0});
      tbl.push_back('{1, 1, 0, 4'b0111, 4'b0011, 3'd2, 0, 0, 0, 4'd3, 0});
      tbl.push_back('{1, 1, 0, 4'b0111, 4'b0010, 3'd3, 0, 0, 0, 4'd2, 0});
      tbl.push_back('{1, 1, 0, 4'b0111, 4'b0110, 3'd4, 0, 0, 1, 4'd1, 0});
      tbl.push_back('{1, 1, 0, 4'b0111, 4'b0111, 3'd5, 0, 1, 1, 4'd0, 0});
      tbl.push_back('{1, 1, 0, 4'b0111, 4'b0111, 3'd5, 0, 1, 1, 4'd0, 1});
      // Remote pointer moves to 6 with no local inc: empty drops.
      tbl.push_back('{1, 0, 0, 4'b0101, 4'b0111, 3'd5, 0, 0, 1, 4'd1, 1});

      rst = 1'b1; inc_w = 0; clear_w = 0; inc_r = 0; clear_r = 0;
      sync_w = 4'b0000; sync_r = 4'b0111;

      repeat (2) edge_wait();
      chk_out("rst_wr", 0, 4'b0000, 3'd0, 0, 0, 0, 4'd0, 0);
      chk_out("rst_rd", 1, 4'b0000, 3'd0, 0, 1, 1, 4'd0, 0);
      @(negedge clk);
      rst = 1'b0;
      edge_wait();

      foreach (tbl[i]) begin
         @(negedge clk);
         if (tbl[i].side == 1'b0) begin
            inc_w = tbl[i].inc; clear_w = tbl[i].clr; sync_w = tbl[i].sync;
            inc_r = 0; clear_r = 0;
         end else begin
            inc_r = tbl[i].inc; clear_r = tbl[i].clr; sync_r = tbl[i].sync;
            inc_w = 0; clear_w = 0;
         end
         edge_wait();
         chk_out($sformatf("tbl[%0d]", i), tbl[i].side, tbl[i].gray, tbl[i].bin,
                 tbl[i].msb, tbl[i].flag, tbl[i].almost, tbl[i].level, tbl[i].err);
      end

      // Clear with remote pointer binary 13 (gray 1011): full lands at ptr 5.
      @(negedge clk);
      inc_r = 0; clear_r = 0;
      inc_w = 0; clear_w = 1; sync_w = 4'b1011;
      edge_wait();
      chk_out("clr0", 0, 4'b0000, 3'd0, 0, 0, 0, 4'd3, 0);
      @(negedge clk);
      clear_w = 0; inc_w = 1;
      repeat (5) edge_wait();
      chk_out("full5", 0, 4'b0111, 3'd5, 0, 1, 1, 4'd8, 0);
      edge_wait();
      chk_out("ovf5", 0, 4'b0111, 3'd5, 0, 1, 1, 4'd8, 1);
      // Clear and inc together: clear wins.
      @(negedge clk);
      clear_w = 1;
      edge_wait();
      chk_out("clr_inc", 0, 4'b0000, 3'd0, 0, 0, 0, 4'd3, 0);

      // Wrap: remote trails the next pointer by 3, level stays 3.
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         clear_w = 0; inc_w = 1;
         sync_w = to_gray(4'(i - 3));
         edge_wait();
         chk_out($sformatf("wrap[%0d]", i), 0, to_gray(4'(i)), 3'(i),
                 ((i / 8) % 2) == 1, 0, 0, 4'd3, 0);
      end

      // Read side: clear, remote pointer 8, advance to 6, then reset.
      @(negedge clk);
      inc_w = 0;
      clear_r = 1; sync_r = 4'b1100;
      edge_wait();
      chk_out("rd_clr", 1, 4'b0000, 3'd0, 0, 0, 0, 4'd8, 0);
      @(negedge clk);
      clear_r = 0; inc_r = 1;
      repeat (6) edge_wait();
      chk_out("rd_ptr6", 1, 4'b0101, 3'd6, 0, 0, 0, 4'd2, 0);
      @(negedge clk);
      rst = 1; inc_w = 1;
      edge_wait();
      chk_out("mid_rst_rd", 1, 4'b0000, 3'd0, 0, 1, 1, 4'd0, 0);
      chk_out("mid_rst_wr", 0, 4'b0000, 3'd0, 0, 0, 0, 4'd0, 0);

      @(negedge clk);
      rst = 0; inc_w = 0; inc_r = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
